// File: rtl/scramble_ctrl.sv
// Per-packet sequencer for the BLE whitening core: seeds the core LFSR, passes the
// unwhitened preamble/AA bits, then routes PDU+CRC bits through the core. Optional status via SCRAMBLE_CTRL_STATUS_EN.
module scramble_ctrl #(
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int BYPASS_BITS              = 40,
    parameter int LEN_BIT_WIDTH            = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    input  logic [LEN_BIT_WIDTH-1:0]            pdu_len_byte,
    input  logic                                start,
    input  logic                                abort,
    input  logic                                data_in,
    input  logic                                data_in_valid,
    output logic                                data_in_ready,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] core_channel_number,
    output logic                                core_channel_number_load,
    output logic                                core_data_in,
    output logic                                core_data_in_valid,
    input  logic                                core_data_out,
    input  logic                                core_data_out_valid,
    output logic                                data_out,
    output logic                                data_out_valid,
    output logic                                busy,
    output logic                                done
`ifdef SCRAMBLE_CTRL_STATUS_EN
    ,
    output logic [15:0]                         pkt_cnt,
    output logic [7:0]                          abort_cnt
`endif
);

    // state  | meaning
    // IDLE   | waiting for start
    // LOAD   | one cycle, core LFSR seeded with latched channel
    // BYPASS | BYPASS_BITS bits passed through unwhitened
    // WHITEN | pdu_len_byte*8 bits routed through the core
    // DONE   | one cycle, done pulse with last output bit
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BYPASS,
        S_WHITEN,
        S_DONE
    } state_t;

    localparam int CNT_W = LEN_BIT_WIDTH + 3;
    localparam logic [CNT_W-1:0] BYP_LOAD = CNT_W'(BYPASS_BITS);

    state_t                          state, state_nxt;
    logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] ch_q;
    logic [LEN_BIT_WIDTH-1:0]        len_q;
    logic [CNT_W-1:0]                cnt, cnt_nxt;
    logic [CNT_W-1:0]                whiten_bits;
    logic                            byp_valid;
    logic                            byp_bit;
    logic                            start_ok;

    assign whiten_bits = {len_q, 3'b000};
    assign start_ok    = (state == S_IDLE) && start && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ch_q      <= '0;
            len_q     <= '0;
            cnt       <= '0;
            byp_valid <= 1'b0;
            byp_bit   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            byp_valid <= (state == S_BYPASS) && data_in_valid;
            if (start_ok) begin
                ch_q  <= channel_number;
                len_q <= pdu_len_byte;
            end
            if ((state == S_BYPASS) && data_in_valid) begin
                byp_bit <= data_in;
            end
        end
    end

    // cnt holds the number of bits still to accept in the current phase
    always_comb begin
        state_nxt                = state;
        cnt_nxt                  = cnt;
        data_in_ready            = 1'b0;
        core_data_in_valid       = 1'b0;
        core_channel_number_load = 1'b0;
        done                     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                core_channel_number_load = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (BYPASS_BITS != 0) begin
                    state_nxt = S_BYPASS;
                    cnt_nxt   = BYP_LOAD;
                end else if (len_q != '0) begin
                    state_nxt = S_WHITEN;
                    cnt_nxt   = whiten_bits;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_BYPASS: begin
                data_in_ready = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (data_in_valid) begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        if (len_q != '0) begin
                            state_nxt = S_WHITEN;
                            cnt_nxt   = whiten_bits;
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end
                end
            end
            S_WHITEN: begin
                data_in_ready      = 1'b1;
                core_data_in_valid = data_in_valid;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (data_in_valid) begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign core_channel_number = ch_q;
    assign core_data_in        = data_in;
    assign data_out_valid      = byp_valid | core_data_out_valid;
    assign data_out            = core_data_out_valid ? core_data_out : byp_bit;
    assign busy                = (state != S_IDLE);

`ifdef SCRAMBLE_CTRL_STATUS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt   <= '0;
            abort_cnt <= '0;
        end else begin
            if (state == S_DONE) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (abort && (state != S_IDLE) && (abort_cnt != 8'hFF)) begin
                abort_cnt <= abort_cnt + 8'd1;
            end
        end
    end
`endif

endmodule
